debug_hex_rx: RTL and testbench

Receive-side companion to the debug hex transmitter. Consumes bytes from the UART receiver and parses ASCII hexadecimal text into 32-bit words. A word is 1–8 hex digits terminated by CR or LF. The block sits between `uart_rx` and the debug register/command logic, so a host terminal can write 32-bit values into the design.

---
 rtl/debug_hex_rx_if.sv | 34 +++
 rtl/debug_hex_rx.sv | 178 +++++++++++++++++
 tb/tb_debug_hex_rx.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_hex_rx_if.sv
// rtl/debug_hex_rx_if.sv - byte-in / word-out bundle for debug_hex_rx
// Echo signals exist only when DEBUG_HEX_RX_ECHO_EN is defined.
interface debug_hex_rx_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        word_valid;
  logic [31:0] word_data;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;
`ifdef DEBUG_HEX_RX_ECHO_EN
  logic        uart_tx_start;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_busy;
`endif

  modport slave (
    input  rx_valid, rx_data,
`ifdef DEBUG_HEX_RX_ECHO_EN
    input  uart_tx_busy,
    output uart_tx_start, uart_tx_data,
`endif
    output word_valid, word_data, err, err_code, busy
  );

  modport master (
    output rx_valid, rx_data,
`ifdef DEBUG_HEX_RX_ECHO_EN
    output uart_tx_busy,
    input  uart_tx_start, uart_tx_data,
`endif
    input  word_valid, word_data, err, err_code, busy
  );
endinterface

// File: rtl/debug_hex_rx.sv
// rtl/debug_hex_rx.sv - ASCII hex line parser producing 32-bit words
// Optional byte echo to a UART transmitter under DEBUG_HEX_RX_ECHO_EN.
module debug_hex_rx (
  input  logic           clk,
  input  logic           rst,
  debug_hex_rx_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIGITS  = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        word_valid_q, word_valid_d;
  logic [31:0] word_data_q, word_data_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        busy_q, busy_d;

  logic        is_digit, is_term;
  logic [3:0]  nib;

  // Letters A-F / a-f have low nibble 1..6, so +9 gives 10..15.
  always_comb begin
    is_digit = 1'b0;
    nib      = 4'd0;
    if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
      is_digit = 1'b1;
      nib      = bus.rx_data[3:0];
    end else if ((bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) ||
                 (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66)) begin
      is_digit = 1'b1;
      nib      = bus.rx_data[3:0] + 4'd9;
    end
    is_term = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      acc_q        <= 32'd0;
      cnt_q        <= 4'd0;
      word_valid_q <= 1'b0;
      word_data_q  <= 32'd0;
      err_q        <= 1'b0;
      err_code_q   <= 2'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.rx_valid) begin
      case (state_q)
        ST_IDLE:    if (is_digit) state_d = ST_DIGITS;
                    else if (!is_term) state_d = ST_DISCARD;
        ST_DIGITS:  if (is_digit) begin
                      if (cnt_q == 4'd8) state_d = ST_DISCARD;
                    end else if (is_term) state_d = ST_IDLE;
                    else state_d = ST_DISCARD;
        ST_DISCARD: if (is_term) state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    word_valid_d = 1'b0;
    word_data_d  = word_data_q;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    busy_d       = (state_d != ST_IDLE);
    if (bus.rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (is_digit) begin
            acc_d = {28'd0, nib};
            cnt_d = 4'd1;
          end else if (!is_term) begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
          end
        end
        ST_DIGITS: begin
          if (is_digit) begin
            if (cnt_q == 4'd8) begin
              err_d      = 1'b1;
              err_code_d = 2'd2;
            end else begin
              acc_d = {acc_q[27:0], nib};
              cnt_d = cnt_q + 4'd1;
            end
          end else if (is_term) begin
            word_valid_d = 1'b1;
            word_data_d  = acc_q;
            acc_d        = 32'd0;
            cnt_d        = 4'd0;
          end else begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
          end
        end
        ST_DISCARD: begin
          if (is_term) begin
            acc_d = 32'd0;
            cnt_d = 4'd0;
          end
        end
        default: begin
          acc_d = 32'd0;
          cnt_d = 4'd0;
        end
      endcase
    end
  end

  assign bus.word_valid = word_valid_q;
  assign bus.word_data  = word_data_q;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;
  assign bus.busy       = busy_q;

`ifdef DEBUG_HEX_RX_ECHO_EN
  logic       buf_full_q, buf_full_d;
  logic [7:0] buf_data_q, buf_data_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q, tx_data_d;

  // Drain and load are exclusive: a byte arriving while full is dropped.
  always_comb begin
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    if (buf_full_q && !bus.uart_tx_busy && !tx_start_q) begin
      tx_start_d = 1'b1;
      tx_data_d  = buf_data_q;
      buf_full_d = 1'b0;
    end else if (bus.rx_valid && !buf_full_q) begin
      buf_full_d = 1'b1;
      buf_data_d = bus.rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full_q <= 1'b0;
      buf_data_q <= 8'd0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'd0;
    end else begin
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign bus.uart_tx_start = tx_start_q;
  assign bus.uart_tx_data  = tx_data_q;
`endif

endmodule

// File: tb/tb_debug_hex_rx.sv
// tb/tb_debug_hex_rx.sv - vector table, corner sequences and random model check
// Echo checks compile in only with DEBUG_HEX_RX_ECHO_EN.
module tb_debug_hex_rx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  debug_hex_rx_if bus_if ();

  debug_hex_rx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0]  b;
    logic        wv;
    logic [31:0] wd;
    logic        er;
    logic [1:0]  ec;
    logic        bz;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(logic [7:0] b, logic wv, logic [31:0] wd,
                              logic er, logic [1:0] ec, logic bz);
    vec_t v;
    v.b = b; v.wv = wv; v.wd = wd; v.er = er; v.ec = ec; v.bz = bz;
    vecs.push_back(v);
  endfunction

  // Non-deciding bytes inside a word: only busy is high, held values unchanged.
  function automatic void add_run(string s, logic [31:0] wd, logic [1:0] ec);
    for (int i = 0; i < s.len(); i++) add(s[i], 1'b0, wd, 1'b0, ec, 1'b1);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_outs(string tag, logic wv, logic [31:0] wd, logic er,
                            logic [1:0] ec, logic bz);
    check({tag, ".word_valid"}, {31'd0, bus_if.word_valid}, {31'd0, wv});
    check({tag, ".word_data"},  bus_if.word_data, wd);
    check({tag, ".err"},        {31'd0, bus_if.err}, {31'd0, er});
    check({tag, ".err_code"},   {30'd0, bus_if.err_code}, {30'd0, ec});
    check({tag, ".busy"},       {31'd0, bus_if.busy}, {31'd0, bz});
  endtask

  task automatic drive(logic [7:0] b);
    @(negedge clk);
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle1();
    @(negedge clk);
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'($urandom);
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: the line so far as a list of digit values.
  int unsigned m_digits[$];
  bit          m_discard;
  logic [31:0] m_wd;
  logic [1:0]  m_ec;

  function automatic int hexval(logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    if (b >= "a" && b <= "f") return int'(b) - 87;
    return -1;
  endfunction

  function automatic void model_reset();
    m_digits.delete();
    m_discard = 1'b0;
    m_wd = 32'd0;
    m_ec = 2'd0;
  endfunction

  function automatic void model_step(logic [7:0] b, output logic wv, output logic er);
    bit term = (b == 8'h0D) || (b == 8'h0A);
    int hv = hexval(b);
    longint unsigned v = 0;
    wv = 1'b0;
    er = 1'b0;
    if (m_discard) begin
      if (term) begin m_discard = 1'b0; m_digits.delete(); end
    end else if (term) begin
      if (m_digits.size() > 0) begin
        foreach (m_digits[k]) v = v * 16 + m_digits[k];
        m_wd = v[31:0];
        wv = 1'b1;
        m_digits.delete();
      end
    end else if (hv < 0) begin
      er = 1'b1; m_ec = 2'd1; m_discard = 1'b1;
    end else if (m_digits.size() == 8) begin
      er = 1'b1; m_ec = 2'd2; m_discard = 1'b1;
    end else begin
      m_digits.push_back(hv);
    end
  endfunction

  function automatic logic model_busy();
    return m_discard || (m_digits.size() > 0);
  endfunction

  task automatic do_reset(int n);
    @(negedge clk);
    rst = 1'b1;
    bus_if.rx_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_outs("reset", 1'b0, 32'd0, 1'b0, 2'd0, 1'b0);
`ifdef DEBUG_HEX_RX_ECHO_EN
      check("reset.uart_tx_start", {31'd0, bus_if.uart_tx_start}, 32'd0);
      check("reset.uart_tx_data", {24'd0, bus_if.uart_tx_data}, 32'd0);
`endif
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [7:0] rand_illegal();
    logic [7:0] b;
    do b = 8'($urandom); while (hexval(b) >= 0 || b == 8'h0D || b == 8'h0A);
    return b;
  endfunction

  task automatic rand_byte_checked(logic [7:0] b);
    logic wv, er;
    drive(b);
    model_step(b, wv, er);
    check_outs("rand", wv, m_wd, er, m_ec, model_busy());
    repeat ($urandom_range(0, 2)) begin
      idle1();
      check_outs("rand_gap", 1'b0, m_wd, 1'b0, m_ec, model_busy());
    end
  endtask

`ifdef DEBUG_HEX_RX_ECHO_EN
  logic [7:0] echo_q[$];
  int         echo_consec = 0;
  logic       prev_start = 1'b0;
  always @(negedge clk) begin
    if (bus_if.uart_tx_start) begin
      echo_q.push_back(bus_if.uart_tx_data);
      if (prev_start) echo_consec++;
    end
    prev_start = bus_if.uart_tx_start;
  end
`endif

  initial begin
    string hexd;
    hexd = "0123456789ABCDEFabcdef";
    rst = 1'b1;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'd0;
`ifdef DEBUG_HEX_RX_ECHO_EN
    bus_if.uart_tx_busy = 1'b0;
`endif
    model_reset();
    do_reset(3);

    // Reset in the middle of a word throws the partial word away.
    drive("A");
    check_outs("mid_a", 1'b0, 32'd0, 1'b0, 2'd0, 1'b1);
    drive("B");
    check_outs("mid_b", 1'b0, 32'd0, 1'b0, 2'd0, 1'b1);
    do_reset(2);
    drive("C");
    check_outs("post_c", 1'b0, 32'd0, 1'b0, 2'd0, 1'b1);
    drive(8'h0D);
    check_outs("post_cr", 1'b1, 32'h0000000C, 1'b0, 2'd0, 1'b0);
    idle1();
    check_outs("post_idle", 1'b0, 32'h0000000C, 1'b0, 2'd0, 1'b0);
    do_reset(1);

    add_run("1234ABCD", 32'd0, 2'd0);
    add(8'h0D, 1'b1, 32'h1234ABCD, 1'b0, 2'd0, 1'b0);
    add_run("ff", 32'h1234ABCD, 2'd0);
    add(8'h0D, 1'b1, 32'h000000FF, 1'b0, 2'd0, 1'b0);
    add(8'h0A, 1'b0, 32'h000000FF, 1'b0, 2'd0, 1'b0);
    add_run("0", 32'h000000FF, 2'd0);
    add(8'h0A, 1'b1, 32'h00000000, 1'b0, 2'd0, 1'b0);
    add_run("12", 32'd0, 2'd0);
    add("G", 1'b0, 32'd0, 1'b1, 2'd1, 1'b1);
    add("4", 1'b0, 32'd0, 1'b0, 2'd1, 1'b1);
    add(8'h0D, 1'b0, 32'd0, 1'b0, 2'd1, 1'b0);
    add_run("5", 32'd0, 2'd1);
    add(8'h0D, 1'b1, 32'h00000005, 1'b0, 2'd1, 1'b0);
    add_run("12345678", 32'h5, 2'd1);
    add("9", 1'b0, 32'h5, 1'b1, 2'd2, 1'b1);
    add(8'h0D, 1'b0, 32'h5, 1'b0, 2'd2, 1'b0);
    add(8'h0D, 1'b0, 32'h5, 1'b0, 2'd2, 1'b0);
    add_run("FFFFFFFF", 32'h5, 2'd2);
    add(8'h0A, 1'b1, 32'hFFFFFFFF, 1'b0, 2'd2, 1'b0);
    add("x", 1'b0, 32'hFFFFFFFF, 1'b1, 2'd1, 1'b1);
    add_run("zz1", 32'hFFFFFFFF, 2'd1);
    add(8'h0D, 1'b0, 32'hFFFFFFFF, 1'b0, 2'd1, 1'b0);
    add_run("a", 32'hFFFFFFFF, 2'd1);
    add(8'h0D, 1'b1, 32'h0000000A, 1'b0, 2'd1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].b);
      check_outs($sformatf("vec%0d", i), vecs[i].wv, vecs[i].wd, vecs[i].er,
                 vecs[i].ec, vecs[i].bz);
    end
    idle1();
    check_outs("vec_end", 1'b0, 32'h0000000A, 1'b0, 2'd1, 1'b0);

    do_reset(1);
    for (int line = 0; line < 300; line++) begin
      int len = $urandom_range(0, 10);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 19) == 0) rand_byte_checked(rand_illegal());
        else rand_byte_checked(hexd[$urandom_range(0, hexd.len() - 1)]);
        if ($urandom_range(0, 199) == 0) do_reset(1);
      end
      rand_byte_checked($urandom_range(0, 1) ? 8'h0D : 8'h0A);
      if ($urandom_range(0, 1) == 1) rand_byte_checked(8'h0A);
    end

`ifdef DEBUG_HEX_RX_ECHO_EN
    do_reset(1);
    echo_q.delete();
    drive("A"); repeat (4) idle1();
    drive("5"); repeat (4) idle1();
    drive(8'h0D);
    check_outs("echo1_cr", 1'b1, 32'h000000A5, 1'b0, 2'd0, 1'b0);
    repeat (4) idle1();
    check("echo1.count", echo_q.size(), 3);
    if (echo_q.size() == 3) begin
      check("echo1.b0", {24'd0, echo_q[0]}, 32'h41);
      check("echo1.b1", {24'd0, echo_q[1]}, 32'h35);
      check("echo1.b2", {24'd0, echo_q[2]}, 32'h0D);
    end
    echo_q.delete();
    @(negedge clk);
    bus_if.uart_tx_busy = 1'b1;
    drive("A");
    drive("5");
    idle1();
    @(negedge clk);
    bus_if.uart_tx_busy = 1'b0;
    repeat (4) idle1();
    drive(8'h0D);
    check_outs("echo2_cr", 1'b1, 32'h000000A5, 1'b0, 2'd0, 1'b0);
    repeat (4) idle1();
    check("echo2.count", echo_q.size(), 2);
    if (echo_q.size() == 2) begin
      check("echo2.b0", {24'd0, echo_q[0]}, 32'h41);
      check("echo2.b1", {24'd0, echo_q[1]}, 32'h0D);
    end
    check("echo.consecutive_start", echo_consec, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
